// File: rtl/vga_timing_monitor_if.sv
// Purpose: carries the video signals under test into vga_timing_monitor
// and its recovered-timing results back out.
// The master modport belongs to whoever drives the video stream.
// The slave modport belongs to the monitor itself.
// Signals:
//   pixel_clk  - 25 MHz pixel clock, sampled as data by the monitor
//   hs, vs     - active-low sync pulses under test
//   blank      - high during active video
//   err_clear  - one-cycle pulse that clears the sticky error flags
//   RecX, RecY - recovered pixel coordinates
//   active     - expected-active flag for (RecX, RecY)
//   locked     - timing locked
//   h_err, v_err, b_err - sticky mismatch flags for hs, vs and blank
//   frame_count - completed checked frames, wrapping
interface vga_timing_monitor_if;
  logic       pixel_clk;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       err_clear;
  logic [9:0] RecX;
  logic [9:0] RecY;
  logic       active;
  logic       locked;
  logic       h_err;
  logic       v_err;
  logic       b_err;
  logic [7:0] frame_count;

  modport master (
    output pixel_clk, hs, vs, blank, err_clear,
    input  RecX, RecY, active, locked, h_err, v_err, b_err, frame_count
  );

  modport slave (
    input  pixel_clk, hs, vs, blank, err_clear,
    output RecX, RecY, active, locked, h_err, v_err, b_err, frame_count
  );
endinterface

// File: rtl/vga_timing_monitor.sv
// Purpose: watches a VGA controller's hs/vs/blank outputs.
// It recovers the pixel position from the sync edges.
// Once aligned, it checks every pixel against the nominal timing.
// It reports sticky mismatch flags, a locked indication and a frame counter.
// Ports:
//   Clk   - 50 MHz system clock; all state changes on its rising edge
//   Reset - asynchronous, active-low reset
//   vif   - slave side of vga_timing_monitor_if (video in, results out)
module vga_timing_monitor #(
  parameter int H_TOTAL      = 800,
  parameter int H_VISIBLE    = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 751,
  parameter int V_TOTAL      = 525,
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491
) (
  input logic                 Clk,
  input logic                 Reset,
  vga_timing_monitor_if.slave vif
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END   = 10'(H_SYNC_END);
  localparam logic [9:0] VS_START = 10'(V_SYNC_START);
  localparam logic [9:0] VS_END   = 10'(V_SYNC_END);

  typedef enum logic [1:0] {HUNT, HALIGN, CHECK, LOCKED} state_t;

  state_t     state_q, state_d;
  logic       pclk_q;
  logic       primed_q, primed_d;
  logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic       blank_prev_q, blank_prev_d;
  logic [1:0] good_q, good_d;
  logic [7:0] frame_q, frame_d;
  logic       locked_q, locked_d, active_q, active_d;
  logic       h_err_q, h_err_d, v_err_q, v_err_d, b_err_q, b_err_d;

  logic       tick, h_wrap, frame_wrap, checking;
  logic [9:0] hcnt_inc, vcnt_inc;
  logic       hs_exp, vs_exp, blank_exp, h_mis, v_mis, b_mis;

  assign tick = vif.pixel_clk & ~pclk_q;

  // Free-running position of the pixel sampled on this tick.
  // Expected levels are derived from that position, so a sample is always
  // judged against the coordinate it will be reported at.
  always_comb begin
    h_wrap     = (hcnt_q == H_LAST);
    frame_wrap = h_wrap && (vcnt_q == V_LAST);
    hcnt_inc   = h_wrap ? 10'd0 : hcnt_q + 10'd1;
    if (!h_wrap)                 vcnt_inc = vcnt_q;
    else if (vcnt_q == V_LAST)   vcnt_inc = 10'd0;
    else                         vcnt_inc = vcnt_q + 10'd1;
    hs_exp    = !((hcnt_inc >= HS_START) && (hcnt_inc <= HS_END));
    vs_exp    = !((vcnt_inc >= VS_START) && (vcnt_inc <= VS_END));
    blank_exp = (hcnt_inc < H_VIS) && (vcnt_inc < V_VIS);
    checking  = tick && ((state_q == CHECK) || (state_q == LOCKED));
    h_mis     = checking && (vif.hs    != hs_exp);
    v_mis     = checking && (vif.vs    != vs_exp);
    b_mis     = checking && (vif.blank != blank_exp);
  end

  // Next-state logic. Only tick cycles move the counters and the FSM.
  // err_clear acts on any cycle but loses to a mismatch on the same cycle.
  // primed_q blocks edge detection until one real sample has been taken,
  // so a sync held low through reset release is not seen as a fresh edge.
  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    hs_prev_d    = hs_prev_q;
    vs_prev_d    = vs_prev_q;
    blank_prev_d = blank_prev_q;
    good_d       = good_q;
    frame_d      = frame_q;
    locked_d     = locked_q;
    active_d     = active_q;
    h_err_d      = vif.err_clear ? 1'b0 : h_err_q;
    v_err_d      = vif.err_clear ? 1'b0 : v_err_q;
    b_err_d      = vif.err_clear ? 1'b0 : b_err_q;

    if (tick) begin
      hcnt_d       = hcnt_inc;
      vcnt_d       = vcnt_inc;
      hs_prev_d    = vif.hs;
      vs_prev_d    = vif.vs;
      blank_prev_d = vif.blank;
      primed_d     = 1'b1;
      case (state_q)
        HUNT: begin
          if (primed_q && hs_prev_q && !vif.hs) begin
            hcnt_d  = HS_START;
            state_d = HALIGN;
          end
        end
        HALIGN: begin
          if (primed_q && vs_prev_q && !vif.vs) begin
            vcnt_d  = VS_START;
            state_d = CHECK;
          end
        end
        default: begin
          if (h_mis || v_mis || b_mis) begin
            if (h_mis) h_err_d = 1'b1;
            if (v_mis) v_err_d = 1'b1;
            if (b_mis) b_err_d = 1'b1;
            state_d = HUNT;
            good_d  = 2'd0;
          end else if (frame_wrap) begin
            frame_d = frame_q + 8'd1;
            if (good_q != 2'd3) good_d = good_q + 2'd1;
            if (good_d >= 2'd2) state_d = LOCKED;
          end
        end
      endcase
      locked_d = (state_d == LOCKED);
      active_d = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
    end
  end

  // Sync history resets idle-high; everything else resets to zero.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= HUNT;
      pclk_q       <= 1'b0;
      primed_q     <= 1'b0;
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      blank_prev_q <= 1'b0;
      good_q       <= 2'd0;
      frame_q      <= 8'd0;
      locked_q     <= 1'b0;
      active_q     <= 1'b0;
      h_err_q      <= 1'b0;
      v_err_q      <= 1'b0;
      b_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pclk_q       <= vif.pixel_clk;
      primed_q     <= primed_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      hs_prev_q    <= hs_prev_d;
      vs_prev_q    <= vs_prev_d;
      blank_prev_q <= blank_prev_d;
      good_q       <= good_d;
      frame_q      <= frame_d;
      locked_q     <= locked_d;
      active_q     <= active_d;
      h_err_q      <= h_err_d;
      v_err_q      <= v_err_d;
      b_err_q      <= b_err_d;
    end
  end

  assign vif.RecX        = hcnt_q;
  assign vif.RecY        = vcnt_q;
  assign vif.active      = active_q;
  assign vif.locked      = locked_q;
  assign vif.h_err       = h_err_q;
  assign vif.v_err       = v_err_q;
  assign vif.b_err       = b_err_q;
  assign vif.frame_count = frame_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Purpose: self-checking bench for vga_timing_monitor.
// It runs a reduced-size raster so that several frames fit in a short run.
// A reference model predicts the outputs for every pixel.
// Predictions are queued when the pixel is driven and compared after its tick.
// A vector table injects single-pixel faults and states the flags each
// fault must raise.
module tb_vga_timing_monitor;

  localparam int H_TOTAL      = 20;
  localparam int H_VISIBLE    = 12;
  localparam int H_SYNC_START = 14;
  localparam int H_SYNC_END   = 16;
  localparam int V_TOTAL      = 10;
  localparam int V_VISIBLE    = 6;
  localparam int V_SYNC_START = 7;
  localparam int V_SYNC_END   = 8;
  localparam int FRAME        = H_TOTAL * V_TOTAL;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic       lock;
    logic       he;
    logic       ve;
    logic       be;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int kind;   // 1 invert hs, 2 invert blank, 3 invert vs
    int fh;
    int fv;
    bit clr_same;
    bit eh;
    bit ev;
    bit eb;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  vga_timing_monitor_if vif();

  vga_timing_monitor #(
    .H_TOTAL(H_TOTAL), .H_VISIBLE(H_VISIBLE),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
    .V_TOTAL(V_TOTAL), .V_VISIBLE(V_VISIBLE),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .vif(vif)
  );

  always #10 Clk = ~Clk;

  // Reference model state
  int   m_state, mh, mv, m_good, m_fc;
  bit   m_active, m_locked, m_he, m_ve, m_be, m_phs, m_pvs, m_primed;
  obs_t exp_q[$];

  // Stream generator position and one-shot fault
  int gen_h = 0, gen_v = 0;
  int f_kind = 0, f_h = 0, f_v = 0;
  bit f_clr = 0;

  task automatic check_val(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; mh = 0; mv = 0; m_good = 0; m_fc = 0;
    m_active = 0; m_locked = 0; m_he = 0; m_ve = 0; m_be = 0;
    m_phs = 1; m_pvs = 1; m_primed = 0;
    exp_q.delete();
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.x = 10'(mh); o.y = 10'(mv); o.act = m_active; o.lock = m_locked;
    o.he = m_he; o.ve = m_ve; o.be = m_be; o.fc = 8'(m_fc);
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o.x = vif.RecX; o.y = vif.RecY; o.act = vif.active; o.lock = vif.locked;
    o.he = vif.h_err; o.ve = vif.v_err; o.be = vif.b_err; o.fc = vif.frame_count;
    return o;
  endfunction

  task automatic compare_obs(input string name, input obs_t a, input obs_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("[TB] FAIL %s: got x=%0d y=%0d act=%0b lock=%0b hvb=%0b%0b%0b fc=%0d, expected x=%0d y=%0d act=%0b lock=%0b hvb=%0b%0b%0b fc=%0d",
               name, a.x, a.y, a.act, a.lock, a.he, a.ve, a.be, a.fc,
               e.x, e.y, e.act, e.lock, e.he, e.ve, e.be, e.fc);
    end
  endtask

  // Advance the model by one sampled pixel and queue the expected outputs.
  task automatic model_tick(input bit s_hs, input bit s_vs, input bit s_bl, input bit clr);
    int nh, nv;
    bit frame_end, hexp, vexp, bexp, bad;
    frame_end = (mh == H_TOTAL - 1) && (mv == V_TOTAL - 1);
    nh = (mh + 1) % H_TOTAL;
    nv = (mh == H_TOTAL - 1) ? (mv + 1) % V_TOTAL : mv;
    if (clr) begin m_he = 0; m_ve = 0; m_be = 0; end
    if (m_state == 0) begin
      if (m_primed && m_phs && !s_hs) begin nh = H_SYNC_START; m_state = 1; end
    end else if (m_state == 1) begin
      if (m_primed && m_pvs && !s_vs) begin nv = V_SYNC_START; m_state = 2; end
    end else begin
      hexp = (nh < H_SYNC_START) || (nh > H_SYNC_END);
      vexp = (nv < V_SYNC_START) || (nv > V_SYNC_END);
      bexp = (nh < H_VISIBLE) && (nv < V_VISIBLE);
      bad = 0;
      if (s_hs != hexp) begin m_he = 1; bad = 1; end
      if (s_vs != vexp) begin m_ve = 1; bad = 1; end
      if (s_bl != bexp) begin m_be = 1; bad = 1; end
      if (bad) begin
        m_state = 0; m_good = 0;
      end else if (frame_end) begin
        m_fc = (m_fc + 1) % 256;
        if (m_good < 3) m_good++;
        if (m_good >= 2) m_state = 3;
      end
    end
    m_locked = (m_state == 3);
    mh = nh; mv = nv;
    m_active = (mh < H_VISIBLE) && (mv < V_VISIBLE);
    m_phs = s_hs; m_pvs = s_vs; m_primed = 1;
    exp_q.push_back(model_obs());
  endtask

  task automatic checkOutput();
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("[TB] FAIL scoreboard: output with no queued expectation");
      return;
    end
    compare_obs("scoreboard", dut_obs(), exp_q.pop_front());
  endtask

  // One pixel: raise pixel_clk with the pixel's levels, then check after the tick.
  task automatic applyStimulus(input bit s_hs, input bit s_vs, input bit s_bl, input bit clr);
    @(negedge Clk);
    vif.hs = s_hs; vif.vs = s_vs; vif.blank = s_bl;
    vif.err_clear = clr; vif.pixel_clk = 1'b1;
    model_tick(s_hs, s_vs, s_bl, clr);
    @(negedge Clk);
    vif.pixel_clk = 1'b0; vif.err_clear = 1'b0;
    checkOutput();
  endtask

  task automatic send_gen(input int n);
    bit s_hs, s_vs, s_bl, clr;
    for (int i = 0; i < n; i++) begin
      s_hs = !((gen_h >= H_SYNC_START) && (gen_h <= H_SYNC_END));
      s_vs = !((gen_v >= V_SYNC_START) && (gen_v <= V_SYNC_END));
      s_bl = (gen_h < H_VISIBLE) && (gen_v < V_VISIBLE);
      clr = 0;
      if (f_kind != 0 && gen_h == f_h && gen_v == f_v) begin
        case (f_kind)
          1:       s_hs = ~s_hs;
          2:       s_bl = ~s_bl;
          default: s_vs = ~s_vs;
        endcase
        clr = f_clr;
        f_kind = 0;
      end
      applyStimulus(s_hs, s_vs, s_bl, clr);
      if (gen_h == H_TOTAL - 1) begin
        gen_h = 0;
        gen_v = (gen_v == V_TOTAL - 1) ? 0 : gen_v + 1;
      end else begin
        gen_h++;
      end
    end
  endtask

  task automatic send_until(input int h, input int v);
    bit hit;
    for (int i = 0; i <= FRAME; i++) begin
      hit = (gen_h == h) && (gen_v == v);
      send_gen(1);
      if (hit) break;
    end
  endtask

  task automatic wait_locked(input string name, input int max_pix);
    int n = 0;
    while (vif.locked !== 1'b1 && n < max_pix) begin
      send_gen(1);
      n++;
    end
    check_val(name, int'(vif.locked), 1);
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    vif.err_clear = 1'b1;
    @(negedge Clk);
    vif.err_clear = 1'b0;
    m_he = 0; m_ve = 0; m_be = 0;
    check_val("clear h_err", int'(vif.h_err), 0);
    check_val("clear v_err", int'(vif.v_err), 0);
    check_val("clear b_err", int'(vif.b_err), 0);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vectors[6];
    vectors[0] = '{1, H_SYNC_END + 1, 2, 0, 1, 0, 0};  // hs pulse one pixel long
    vectors[1] = '{2, 5, 3, 0, 0, 0, 1};               // blank dropped in active video
    vectors[2] = '{3, 4, 1, 1, 0, 1, 0};               // vs glitch with err_clear same cycle
    vectors[3] = '{2, 0, 0, 0, 0, 0, 1};               // blank wrong on the frame-wrap pixel
    vectors[4] = '{2, H_VISIBLE, 0, 0, 0, 0, 1};       // blank high just past active
    vectors[5] = '{3, 0, V_SYNC_END + 1, 0, 0, 1, 0};  // vs pulse one line long

    Reset = 1'b0;
    vif.pixel_clk = 0; vif.hs = 1; vif.vs = 1; vif.blank = 0; vif.err_clear = 0;
    model_reset();
    repeat (3) @(negedge Clk);
    compare_obs("reset outputs", dut_obs(), model_obs());
    check_val("reset state", int'(dut.state_q), 0);
    Reset = 1'b1;

    // Bring-up from the top of a frame
    send_gen(H_SYNC_START);
    check_val("hunt before hs fall", int'(dut.state_q), 0);
    send_gen(1);
    check_val("halign after hs fall", int'(dut.state_q), 1);
    check_val("hcnt loaded", int'(vif.RecX), H_SYNC_START);
    send_gen((H_TOTAL - 1 - H_SYNC_START) + (V_SYNC_START - 1) * H_TOTAL);
    check_val("halign before vs fall", int'(dut.state_q), 1);
    send_gen(1);
    check_val("check after vs fall", int'(dut.state_q), 2);
    check_val("vcnt loaded", int'(vif.RecY), V_SYNC_START);
    send_gen((V_TOTAL - V_SYNC_START) * H_TOTAL);
    check_val("first wrap frame_count", int'(vif.frame_count), 1);
    check_val("first wrap locked", int'(vif.locked), 0);
    send_gen(FRAME - 1);
    check_val("pre-lock locked", int'(vif.locked), 0);
    send_gen(1);
    check_val("lock locked", int'(vif.locked), 1);
    check_val("lock frame_count", int'(vif.frame_count), 2);
    check_val("lock flags", int'({vif.h_err, vif.v_err, vif.b_err}), 0);

    // Single-pixel faults from the locked state
    for (int i = 0; i < 6; i++) begin
      pulse_clear();
      f_kind = vectors[i].kind; f_h = vectors[i].fh; f_v = vectors[i].fv;
      f_clr = vectors[i].clr_same;
      send_until(vectors[i].fh, vectors[i].fv);
      check_val("fault RecX", int'(vif.RecX), vectors[i].fh);
      check_val("fault h_err", int'(vif.h_err), int'(vectors[i].eh));
      check_val("fault v_err", int'(vif.v_err), int'(vectors[i].ev));
      check_val("fault b_err", int'(vif.b_err), int'(vectors[i].eb));
      check_val("fault locked", int'(vif.locked), 0);
      check_val("fault state", int'(dut.state_q), 0);
      wait_locked("relock", 4 * FRAME);
      check_val("sticky flags", int'({vif.h_err, vif.v_err, vif.b_err}),
                int'({vectors[i].eh, vectors[i].ev, vectors[i].eb}));
    end
    pulse_clear();

    // pixel_clk stalled while locked; sync inputs wander but are not sampled
    check_val("stall pre locked", int'(vif.locked), 1);
    repeat (1000) begin
      @(negedge Clk);
      vif.hs = 1'($urandom); vif.vs = 1'($urandom); vif.blank = 1'($urandom);
    end
    compare_obs("stall hold", dut_obs(), model_obs());
    send_gen(FRAME);
    check_val("post stall flags", int'({vif.h_err, vif.v_err, vif.b_err}), 0);
    check_val("post stall locked", int'(vif.locked), 1);

    // Reset mid-frame, then release with hs held low
    send_until(6, 3);
    check_val("pre reset locked", int'(vif.locked), 1);
    @(negedge Clk);
    Reset = 1'b0;
    vif.hs = 1'b0;
    #1;
    check_val("mid reset RecX", int'(vif.RecX), 0);
    check_val("mid reset RecY", int'(vif.RecY), 0);
    check_val("mid reset active", int'(vif.active), 0);
    check_val("mid reset locked", int'(vif.locked), 0);
    check_val("mid reset flags", int'({vif.h_err, vif.v_err, vif.b_err}), 0);
    check_val("mid reset frame_count", int'(vif.frame_count), 0);
    check_val("mid reset state", int'(dut.state_q), 0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("hs held low stays hunt", int'(dut.state_q), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("fresh hs fall halign", int'(dut.state_q), 1);
    check_val("fresh hs fall RecX", int'(vif.RecX), H_SYNC_START);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
